// File: rtl/bcd_count2.sv
`default_nettype none
// ============================================================================
// Module   : bcd_count2
// Purpose  : Two-digit packed-BCD counter (00..MAX) with edge-detected step,
//            synchronous load of validated BCD values, wrap carry pulse and a
//            zero flag. Digits drive seg7 decoders directly.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   MAX       - top count in packed BCD, 8'h01..8'h99 (default 8'h99)
// Ports:
//   clk       in   1  clock, rising edge
//   reset_n   in   1  synchronous active-low reset
//   step      in   1  level request, each 0->1 transition is one count event
//   down      in   1  1 = count down (only when BCD_DOWN_EN is defined)
//   load      in   1  synchronous load strobe
//   load_val  in   8  packed BCD load value
//   ones      out  4  BCD ones digit
//   tens      out  4  BCD tens digit
//   carry     out  1  registered one-cycle wrap pulse
//   zero      out  1  high when {tens,ones} == 8'h00 (combinational)
// Configuration macro:
//   BCD_DOWN_EN - when defined, down selects decrement; otherwise down is
//                 ignored and the block counts up only.
// ============================================================================
module bcd_count2 #(
  parameter logic [7:0] MAX = 8'h99
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       step,
  input  logic       down,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic [3:0] ones,
  output logic [3:0] tens,
  output logic       carry,
  output logic       zero
);

  logic [7:0] cnt_q, cnt_d;
  logic       carry_q, carry_d;
  logic       step_q;
  logic       w_event;
  logic       w_down;
  logic       w_load_ok;

  // step_q resets to 1 so a step held high through reset release is not
  // mistaken for a rising edge.
  assign w_event = step & ~step_q;

`ifdef BCD_DOWN_EN
  assign w_down = down;
`else
  // Direction input is kept on the interface but has no effect.
  logic unused_down;
  assign unused_down = down;
  assign w_down      = 1'b0;
`endif

  // Packed-BCD values with legal nibbles order the same way as their binary
  // encodings, so a plain magnitude compare against MAX is sufficient.
  assign w_load_ok = (load_val[7:4] <= 4'd9) && (load_val[3:0] <= 4'd9) &&
                     (load_val <= MAX);

  always_comb begin
    cnt_d   = cnt_q;
    carry_d = 1'b0;
    if (load) begin
      // Load wins over a coincident count event; that event is dropped.
      if (w_load_ok) begin
        cnt_d = load_val;
      end
    end else if (w_event) begin
      if (w_down) begin
        if (cnt_q == 8'h00) begin
          cnt_d   = MAX;
          carry_d = 1'b1;
        end else if (cnt_q[3:0] == 4'd0) begin
          cnt_d = {cnt_q[7:4] - 4'd1, 4'd9};
        end else begin
          cnt_d = {cnt_q[7:4], cnt_q[3:0] - 4'd1};
        end
      end else begin
        if (cnt_q == MAX) begin
          cnt_d   = 8'h00;
          carry_d = 1'b1;
        end else if (cnt_q[3:0] == 4'd9) begin
          cnt_d = {cnt_q[7:4] + 4'd1, 4'd0};
        end else begin
          cnt_d = {cnt_q[7:4], cnt_q[3:0] + 4'd1};
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q   <= 8'h00;
      carry_q <= 1'b0;
      step_q  <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      step_q  <= step;
    end
  end

  assign tens  = cnt_q[7:4];
  assign ones  = cnt_q[3:0];
  assign carry = carry_q;
  assign zero  = (cnt_q == 8'h00);

endmodule
`default_nettype wire

// File: tb/tb_bcd_count2.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd_count2
// Purpose  : Scoreboard bench for bcd_count2 (MAX = 8'h59). A driver applies
//            one stimulus vector per cycle and pushes the expected outputs
//            from an integer-arithmetic reference model; a monitor pops and
//            compares after every rising edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_count2;

  localparam logic [7:0] MAX  = 8'h59;
  localparam int         MAXI = 59;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       step = 1'b0;
  logic       down = 1'b0;
  logic       load = 1'b0;
  logic [7:0] load_val = 8'h00;
  logic [3:0] ones, tens;
  logic       carry, zero;

  bcd_count2 #(.MAX(MAX)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .step     (step),
    .down     (down),
    .load     (load),
    .load_val (load_val),
    .ones     (ones),
    .tens     (tens),
    .carry    (carry),
    .zero     (zero)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] cnt;
    logic       carry;
    logic       zero;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference model state: count as a plain integer 0..MAXI.
  int m_cnt   = 0;
  bit m_prev  = 1'b1;
  bit m_carry = 1'b0;

`ifdef BCD_DOWN_EN
  localparam bit DOWN_EN = 1'b1;
`else
  localparam bit DOWN_EN = 1'b0;
`endif

  function automatic int bcd2int(input logic [7:0] v);
    return int'(v[7:4]) * 10 + int'(v[3:0]);
  endfunction

  function automatic logic [7:0] int2bcd(input int v);
    logic [3:0] t, o;
    t = 4'(v / 10);
    o = 4'(v % 10);
    return {t, o};
  endfunction

  task automatic check(input string nm, input int act, input int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, req, $time);
  endtask

  // One cycle of stimulus; the model predicts the state after the next edge.
  task automatic drive(input bit rn, input bit st, input bit dn,
                       input bit ld, input logic [7:0] lv);
    exp_t e;
    bit   ev;
    @(negedge clk);
    reset_n  = rn;
    step     = st;
    down     = dn;
    load     = ld;
    load_val = lv;
    if (!rn) begin
      m_cnt = 0; m_prev = 1'b1; m_carry = 1'b0;
    end else begin
      ev      = st && !m_prev;
      m_prev  = st;
      m_carry = 1'b0;
      if (ld) begin
        if (lv[7:4] <= 4'd9 && lv[3:0] <= 4'd9 && bcd2int(lv) <= MAXI)
          m_cnt = bcd2int(lv);
      end else if (ev) begin
        if (DOWN_EN && dn) begin
          if (m_cnt == 0) begin m_cnt = MAXI; m_carry = 1'b1; end
          else m_cnt = m_cnt - 1;
        end else begin
          if (m_cnt == MAXI) begin m_cnt = 0; m_carry = 1'b1; end
          else m_cnt = m_cnt + 1;
        end
      end
    end
    e.cnt   = int2bcd(m_cnt);
    e.carry = m_carry;
    e.zero  = (m_cnt == 0);
    exp_q.push_back(e);
  endtask

  task automatic pulse(input bit dn);
    drive(1, 1, dn, 0, 8'h00);
    drive(1, 0, dn, 0, 8'h00);
  endtask

  task automatic do_load(input logic [7:0] v);
    drive(1, 0, 0, 1, v);
  endtask

  // Directed check of the count right after the edge following the last drive.
  task automatic chk_cnt(input string nm, input logic [7:0] req);
    @(posedge clk);
    #2;
    check(nm, int'({tens, ones}), int'(req));
  endtask

  // Monitor: the DUT presents a new output every cycle.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("count", int'({tens, ones}), int'(e.cnt));
        check("carry", int'(carry), int'(e.carry));
        check("zero",  int'(zero),  int'(e.zero));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int budget;
    logic [7:0] lv;
    // Reset
    drive(0, 0, 0, 0, 8'h00);
    drive(0, 0, 0, 0, 8'h00);
    chk_cnt("reset_count", 8'h00);
    drive(1, 0, 0, 0, 8'h00);

    // Ten pulses: 1..9 then 10
    for (int i = 0; i < 10; i++) pulse(0);
    chk_cnt("ten_pulses", 8'h10);

    // Held step from 05 counts once
    do_load(8'h05);
    for (int i = 0; i < 20; i++) drive(1, 1, 0, 0, 8'h00);
    drive(1, 0, 0, 0, 8'h00);
    chk_cnt("held_step", 8'h06);

    // Wrap at MAX
    do_load(8'h59);
    pulse(0);
    chk_cnt("wrap_max", 8'h00);

    // Invalid / over-MAX loads ignored, valid load accepted
    do_load(8'h3A);
    do_load(8'h99);
    chk_cnt("bad_load", 8'h00);
    do_load(8'h42);
    chk_cnt("good_load", 8'h42);

    // Down counting (increments without the macro)
    do_load(8'h10);
    pulse(1);
    pulse(1);
    chk_cnt("down_two", DOWN_EN ? 8'h08 : 8'h12);
    do_load(8'h00);
    pulse(1);
    chk_cnt("down_wrap", DOWN_EN ? MAX : 8'h01);

    // Load beats a simultaneous step edge
    drive(1, 0, 0, 0, 8'h00);
    drive(1, 1, 0, 1, 8'h25);
    drive(1, 0, 0, 0, 8'h00);
    chk_cnt("load_priority", 8'h25);

    // Step held high across reset release does not count
    drive(1, 1, 0, 0, 8'h00);
    drive(0, 1, 0, 0, 8'h00);
    for (int i = 0; i < 4; i++) drive(1, 1, 0, 0, 8'h00);
    chk_cnt("reset_held_step", 8'h00);
    drive(1, 0, 0, 0, 8'h00);
    drive(1, 1, 0, 0, 8'h00);
    chk_cnt("after_release", 8'h01);

    // Reset coinciding with a wrap event aborts the carry
    drive(1, 0, 0, 0, 8'h00);
    do_load(8'h59);
    drive(0, 1, 0, 0, 8'h00);
    drive(1, 0, 0, 0, 8'h00);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) lv = int2bcd($urandom_range(0, 99));
      else lv = 8'($urandom);
      drive($urandom_range(0, 49) != 0, 1'($urandom), 1'($urandom),
            $urandom_range(0, 9) == 0, lv);
    end
    drive(1, 0, 0, 0, 8'h00);

    budget = 10;
    while (exp_q.size() > 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    #3;
    check("queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
